// File: rtl/bcd_serial_adder.sv
// ---------------------------------------------------------------------------
// bcd_serial_adder
//
// Multi-digit packed-BCD adder/subtractor. One decimal digit is processed per
// clock, least-significant digit first, through a single 4-bit digit adder
// with decimal correction. Subtraction adds the nines' complement of B with
// an inverted borrow-in as the initial carry.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request, accepted only on an edge where ready=1
//   sub      0 = add, 1 = subtract (sampled with start)
//   a, b     packed-BCD operands, digit 0 in bits [3:0] (sampled with start)
//   cin      carry-in (add) / borrow-in (subtract) (sampled with start)
//   ready    high while idle
//   done     one-cycle pulse when sum/cout/invalid are updated
//   sum      packed-BCD result, held until the next done
//   cout     add: decimal carry-out; subtract: 1 = no borrow
//   invalid  a non-BCD digit (>9) was present in the latched operands
// ---------------------------------------------------------------------------
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                sub,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                ready,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                invalid
);

    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               sub_q, sub_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       res_q, res_d;
    logic               flag_q, flag_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               invalid_q, invalid_d;

    // Digit datapath signals
    logic [CNT_W+1:0]   bit_idx;
    logic [3:0]         a_dig;
    logic [3:0]         b_dig;
    logic [3:0]         b_eff;
    logic [4:0]         dig_sum;
    logic [3:0]         res_dig;
    logic               carry_nxt;
    logic               operand_invalid;
    logic               last_digit;

    // Non-BCD detection on the operands being latched
    always_comb begin
        operand_invalid = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
                operand_invalid = 1'b1;
            end
        end
    end

    // Single digit adder with decimal correction. For subtract, 9 - b wraps
    // mod 16 on invalid digits; the result is then only flagged, not blocked.
    always_comb begin
        bit_idx = {cnt_q, 2'b00};
        a_dig   = a_q[bit_idx +: 4];
        b_dig   = b_q[bit_idx +: 4];
        b_eff   = sub_q ? (4'd9 - b_dig) : b_dig;
        dig_sum = {1'b0, a_dig} + {1'b0, b_eff} + {4'd0, carry_q};
        if (dig_sum > 5'd9) begin
            res_dig   = dig_sum[3:0] + 4'd6;
            carry_nxt = 1'b1;
        end else begin
            res_dig   = dig_sum[3:0];
            carry_nxt = 1'b0;
        end
    end

    assign last_digit = (cnt_q == CNT_W'(DIGITS - 1));

    // NOTE: every variable driven here gets its hold value first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sub_d     = sub_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        flag_d    = flag_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        invalid_d = invalid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    // Subtract starts with the "no borrow" carry of the
                    // nines'-complement addition.
                    carry_d = sub ? ~cin : cin;
                    cnt_d   = '0;
                    flag_d  = operand_invalid;
                end
            end
            RUN: begin
                res_d[bit_idx +: 4] = res_dig;
                carry_d             = carry_nxt;
                cnt_d               = cnt_q + CNT_W'(1);
                if (last_digit) begin
                    state_d   = DONE;
                    // res_d already carries the final digit written above.
                    sum_d     = res_d;
                    cout_d    = carry_nxt;
                    invalid_d = flag_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    // NOTE: the result register is small flop storage, so it is reset along
    // with everything else; outputs then read zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            res_q     <= '0;
            flag_q    <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sub_q     <= sub_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            flag_q    <= flag_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            invalid_q <= invalid_d;
        end
    end

    assign ready   = (state_q == IDLE);
    assign done    = (state_q == DONE);
    assign sum     = sum_q;
    assign cout    = cout_q;
    assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_bcd_serial_adder
//
// Self-checking bench for bcd_serial_adder (DIGITS=4). Inputs are driven and
// outputs sampled on the falling clock edge. Expected results come from an
// integer-arithmetic model of decimal add/subtract modulo 10^DIGITS.
// ---------------------------------------------------------------------------
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int MODV   = 10000;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         ready;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         invalid;

    int tests;
    int fails;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .sub     (sub),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .ready   (ready),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .invalid (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int to_int(input logic [W-1:0] v);
        int r;
        r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // {cout, sum} for valid-BCD operands
    function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic msub, input logic mcin);
        int r;
        if (!msub) begin
            r = to_int(ma) + to_int(mb) + int'(mcin);
            return {(r >= MODV), to_bcd(r % MODV)};
        end
        r = to_int(ma) - to_int(mb) - int'(mcin);
        if (r < 0) return {1'b0, to_bcd(r + MODV)};
        return {1'b1, to_bcd(r)};
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // One operation with handshake, latency and pulse-width checks.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic ts, input logic tc,
                         output logic [W-1:0] rs, output logic rc, output logic ri);
        int lat;
        @(negedge clk);
        check("ready_before", ready, 1);
        a = ta; b = tb_v; sub = ts; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        check("ready_in_run", ready, 0);
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, DIGITS + 1);
        rs = sum; rc = cout; ri = invalid;
        @(negedge clk);
        check("done_pulse", done, 0);
        check("ready_after", ready, 1);
    endtask

    task automatic op_check(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                            input logic ts, input logic tc, input logic [W-1:0] es,
                            input logic ec, input logic ei);
        logic [W-1:0] rs;
        logic         rc, ri;
        do_op(ta, tb_v, ts, tc, rs, rc, ri);
        check({tag, "_sum"}, rs, es);
        check({tag, "_cout"}, rc, ec);
        check({tag, "_invalid"}, ri, ei);
    endtask

    // Handshake-phase state
    logic [W:0]   expq[$];
    logic [W:0]   exp_r;
    logic [W-1:0] prev_sum;
    logic [W-1:0] ha, hb;
    logic         hs, hc;
    int           last_done, ndone, nacc, seen;

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_sum", sum, 16'h0000);
        check("idle_cout", cout, 0);
        check("idle_invalid", invalid, 0);
        check("idle_ready", ready, 1);

        // Directed cases
        op_check("add_0999", 16'h0999, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        op_check("add_ovf",  16'h9999, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);
        op_check("add_6_6",  16'h0006, 16'h0006, 1'b0, 1'b0, 16'h0012, 1'b0, 1'b0);
        op_check("sub_5_3",  16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0);
        op_check("sub_3_5",  16'h0003, 16'h0005, 1'b1, 1'b0, 16'h9998, 1'b0, 1'b0);
        op_check("inv_add",  16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1);
        op_check("sub_bin",  16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0998, 1'b1, 1'b0);

        // Reset two cycles into RUN: outputs clear at once, no done pulse
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_sum", sum, 16'h0000);
        check("midrst_cout", cout, 0);
        check("midrst_ready", ready, 1);
        check("midrst_done", done, 0);
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) seen++;
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("midrst_no_done", seen, 0);
        check("midrst_idle", ready, 1);

        // Randomized operations against the integer model
        for (int n = 0; n < 30; n++) begin
            ha = rand_bcd(); hb = rand_bcd();
            hs = 1'($urandom_range(0, 1)); hc = 1'($urandom_range(0, 1));
            exp_r = model(ha, hb, hs, hc);
            op_check("rand", ha, hb, hs, hc, exp_r[W-1:0], exp_r[W], 1'b0);
        end

        // Valid op after an invalid one clears the flag
        op_check("inv_a",   16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1);
        op_check("inv_clr", 16'h0123, 16'h0456, 1'b0, 1'b0, 16'h0579, 1'b0, 1'b0);

        // Start held high with operands changing every cycle
        last_done = -1; ndone = 0; nacc = 0;
        prev_sum  = sum;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (done) begin
                check("hs_queue", (expq.size() > 0), 1);
                if (expq.size() > 0) begin
                    exp_r = expq.pop_front();
                    check("hs_sum", sum, exp_r[W-1:0]);
                    check("hs_cout", cout, exp_r[W]);
                    check("hs_invalid", invalid, 0);
                end
                if (last_done >= 0) check("hs_period", cyc - last_done, 6);
                last_done = cyc;
                prev_sum  = sum;
                ndone++;
            end else begin
                check("hs_sum_stable", sum, prev_sum);
            end
            if (cyc < 40) begin
                ha = rand_bcd(); hb = rand_bcd();
                hs = 1'($urandom_range(0, 1)); hc = 1'($urandom_range(0, 1));
                a = ha; b = hb; sub = hs; cin = hc; start = 1'b1;
                if (ready) begin
                    expq.push_back(model(ha, hb, hs, hc));
                    nacc++;
                end
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("hs_accepts", nacc, 7);
        check("hs_dones", ndone, nacc);
        check("hs_drained", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
